// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan sequencer for a 4x4 active-low matrix keypad. One column is driven
// low at a time. The row inputs are synchronised and then sampled once per
// scan tick. Presses and releases must stay stable for DEBOUNCE_TICKS ticks
// before they are accepted. The debounced key appears on key_code/key_valid,
// and key_event pulses once for each accepted press.
//
// Ports
//   clk_internal  in   1  system clock
//   rst_n         in   1  asynchronous, active-low reset
//   row_in        in   4  keypad rows, active-low, asynchronous to the clock
//   col_out       out  4  column drive, active-low, exactly one bit low
//   key_code      out  4  hex code of the debounced key (holds after release)
//   key_valid     out  1  high while a debounced key is held
//   key_event     out  1  one-cycle pulse when a new press is accepted
//   scan_active   out  1  high while the columns are rotating
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk_internal,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_event,
    output logic       scan_active
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_SCAN      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    logic [3:0]        rs_meta;
    logic [3:0]        rs;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        trk_row;
    logic [1:0]        trk_col;
    logic [1:0]        col_idx;
    logic [1:0]        low_row;
    logic [3:0]        col_rot;

    // Keypad legend: row0 {1,2,3,A}, row1 {4,5,6,B}, row2 {7,8,9,C},
    // row3 {E(*),0,F(#),D}.
    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Rows are asynchronous to the clock. The synchroniser resets to
    // "nothing pressed" so that no press is seen during reset release.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    // Free-running scan-tick divider. A column change lands on a tick edge,
    // so the rows get almost a full period to settle before the next sample.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Decode the column currently driven, pick the lowest pulled-down row,
    // and precompute the rotated column pattern and the saturating counter.
    always_comb begin
        col_idx = 2'd0;
        case (col_out)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        low_row = 2'd3;
        if (!rs[0]) begin
            low_row = 2'd0;
        end else if (!rs[1]) begin
            low_row = 2'd1;
        end else if (!rs[2]) begin
            low_row = 2'd2;
        end

        col_rot  = {col_out[2:0], col_out[3]};
        cnt_next = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;
    end

    // Debounce FSM. It only moves on tick cycles. key_event defaults to low
    // every cycle, so each acceptance gives exactly one pulse. In DEB_REL a
    // bounce back to pressed restarts the release count. It does not return
    // to HELD, so the same press never fires a second event.
    always_ff @(posedge clk_internal or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            cnt       <= '0;
            trk_row   <= 2'd0;
            trk_col   <= 2'd0;
            col_out   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (rs != 4'hF) begin
                            trk_row <= low_row;
                            trk_col <= col_idx;
                            if (DEBOUNCE_TICKS == 1) begin
                                state     <= ST_HELD;
                                cnt       <= CNT_DONE;
                                key_code  <= map_key(low_row, col_idx);
                                key_valid <= 1'b1;
                                key_event <= 1'b1;
                            end else begin
                                state <= ST_DEB_PRESS;
                                cnt   <= CNT_ONE;
                            end
                        end else begin
                            col_out <= col_rot;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (!rs[trk_row]) begin
                            cnt <= cnt_next;
                            if (cnt_next == CNT_DONE) begin
                                state     <= ST_HELD;
                                key_code  <= map_key(trk_row, trk_col);
                                key_valid <= 1'b1;
                                key_event <= 1'b1;
                            end
                        end else begin
                            state   <= ST_SCAN;
                            cnt     <= '0;
                            col_out <= col_rot;
                        end
                    end
                    ST_HELD: begin
                        if (rs[trk_row]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state     <= ST_SCAN;
                                cnt       <= '0;
                                key_valid <= 1'b0;
                                col_out   <= col_rot;
                            end else begin
                                state <= ST_DEB_REL;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (rs[trk_row]) begin
                            cnt <= cnt_next;
                            if (cnt_next == CNT_DONE) begin
                                state     <= ST_SCAN;
                                cnt       <= '0;
                                key_valid <= 1'b0;
                                col_out   <= col_rot;
                            end
                        end else begin
                            cnt <= CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign scan_active = (state == ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Bench for keypad_scan_ctrl with SCAN_DIV=4 and DEBOUNCE_TICKS=3. A keypad
// model pulls row r low whenever a pressed key (r,c) sits on the driven
// column. The directed steps cover the scan rotation, the press, bounce and
// release debouncing, masking of a second key, row priority and the reset
// paths. A randomized phase then presses random keys and compares the
// reported codes against the keypad legend. The legend includes
// same-column pairs where the lowest row must win.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;

    // Keypad legend indexed by row*4+col.
    localparam logic [3:0] KMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic        clk_internal = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_event;
    logic        scan_active;

    logic [15:0] pressed = 16'h0000;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          event_count = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk_internal (clk_internal),
        .rst_n        (rst_n),
        .row_in       (row_in),
        .col_out      (col_out),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_event    (key_event),
        .scan_active  (scan_active)
    );

    always #5 clk_internal = ~clk_internal;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        row_in = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[4'(k)] && !col_out[2'(k % 4)]) begin
                row_in[2'(k / 4)] = 1'b0;
            end
        end
    end

    // Count the cycles in which key_event is high, just after each edge.
    always @(posedge clk_internal) begin
        #1;
        if (key_event === 1'b1) begin
            event_count++;
        end
    end

    // Watchdog that stops a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to a given negedge, counted from the reset release.
    task automatic go_to(input int target);
        while (cyc < target) begin
            @(negedge clk_internal);
            cyc++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_internal);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_internal);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int         base;
        int         r;
        int         r2;
        int         c;
        int         exp_row;
        logic [15:0] keys;
        logic [3:0] exp_col;
        logic       got;

        rst_n = 1'b0;
        applyStimulus(16'h0000);
        repeat (3) @(negedge clk_internal);

        // Step 1: reset values, then rotation every 4 cycles.
        reset_dut();
        go_to(1);
        checkOutput("rst_key_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("rst_key_code", 32'(key_code), 32'(4'h0));
        checkOutput("rst_scan_active", 32'(scan_active), 32'(1'b1));
        go_to(3);
        checkOutput("rot_c0", 32'(col_out), 32'(4'b1110));
        go_to(4);
        checkOutput("rot_c1", 32'(col_out), 32'(4'b1101));
        go_to(8);
        checkOutput("rot_c2", 32'(col_out), 32'(4'b1011));
        go_to(12);
        checkOutput("rot_c3", 32'(col_out), 32'(4'b0111));
        go_to(16);
        checkOutput("rot_wrap", 32'(col_out), 32'(4'b1110));
        checkOutput("rot_no_event", 32'(event_count), 32'(0));

        // Step 2: hold '5'. The first sample tick is at cycle 8, so the
        // press is accepted on the tick at cycle 16.
        applyStimulus(16'h0020);
        reset_dut();
        base = event_count;
        go_to(15);
        checkOutput("p5_pre_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("p5_pre_event", 32'(key_event), 32'(1'b0));
        go_to(16);
        checkOutput("p5_event", 32'(key_event), 32'(1'b1));
        checkOutput("p5_valid", 32'(key_valid), 32'(1'b1));
        checkOutput("p5_code", 32'(key_code), 32'(4'h5));
        go_to(17);
        checkOutput("p5_event_clear", 32'(key_event), 32'(1'b0));
        go_to(40);
        checkOutput("p5_col_frozen", 32'(col_out), 32'(4'b1101));
        checkOutput("p5_scan_inactive", 32'(scan_active), 32'(1'b0));
        checkOutput("p5_one_event", 32'(event_count - base), 32'(1));

        // Asynchronous reset in the middle of a cycle while '5' is held.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_col", 32'(col_out), 32'(4'b1110));
        checkOutput("async_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("async_event", 32'(key_event), 32'(1'b0));
        checkOutput("async_code", 32'(key_code), 32'(4'h0));
        checkOutput("async_scan", 32'(scan_active), 32'(1'b1));

        // Step 3: press '5' for two ticks only, then release.
        applyStimulus(16'h0020);
        reset_dut();
        base = event_count;
        go_to(12);
        checkOutput("short_debouncing", 32'(scan_active), 32'(1'b0));
        applyStimulus(16'h0000);
        go_to(16);
        checkOutput("short_col_adv", 32'(col_out), 32'(4'b1011));
        checkOutput("short_scan", 32'(scan_active), 32'(1'b1));
        go_to(24);
        checkOutput("short_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("short_no_event", 32'(event_count - base), 32'(0));

        // Step 4: a release bounce must not give a second event.
        applyStimulus(16'h0020);
        reset_dut();
        base = event_count;
        go_to(16);
        checkOutput("bounce_event", 32'(key_event), 32'(1'b1));
        applyStimulus(16'h0000);
        go_to(24);
        checkOutput("bounce_valid_rel2", 32'(key_valid), 32'(1'b1));
        applyStimulus(16'h0020);
        go_to(28);
        checkOutput("bounce_valid_repress", 32'(key_valid), 32'(1'b1));
        applyStimulus(16'h0000);
        go_to(32);
        checkOutput("bounce_valid_rel1", 32'(key_valid), 32'(1'b1));
        go_to(40);
        checkOutput("bounce_valid_fall", 32'(key_valid), 32'(1'b0));
        checkOutput("bounce_scan", 32'(scan_active), 32'(1'b1));
        go_to(48);
        checkOutput("bounce_single_event", 32'(event_count - base), 32'(1));

        // Step 5: hold 'A', add '8' while held, then release 'A'.
        applyStimulus(16'h0008);
        reset_dut();
        base = event_count;
        go_to(24);
        checkOutput("a_event", 32'(key_event), 32'(1'b1));
        checkOutput("a_code", 32'(key_code), 32'(4'hA));
        go_to(26);
        applyStimulus(16'h0208);
        go_to(40);
        checkOutput("a_masked_8", 32'(event_count - base), 32'(1));
        checkOutput("a_col_frozen", 32'(col_out), 32'(4'b0111));
        checkOutput("a_code_hold", 32'(key_code), 32'(4'hA));
        applyStimulus(16'h0200);
        go_to(52);
        checkOutput("a_released", 32'(key_valid), 32'(1'b0));
        checkOutput("a_code_after_rel", 32'(key_code), 32'(4'hA));
        go_to(67);
        checkOutput("8_not_yet", 32'(event_count - base), 32'(1));
        go_to(68);
        checkOutput("8_event", 32'(key_event), 32'(1'b1));
        checkOutput("8_code", 32'(key_code), 32'(4'h8));
        checkOutput("8_col", 32'(col_out), 32'(4'b1101));

        // Step 6: rows 1 and 3 on column 2, then reset while HELD.
        applyStimulus(16'h4040);
        reset_dut();
        base = event_count;
        go_to(20);
        checkOutput("prio_event", 32'(key_event), 32'(1'b1));
        checkOutput("prio_code", 32'(key_code), 32'(4'h6));
        go_to(24);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("held_rst_col", 32'(col_out), 32'(4'b1110));
        checkOutput("held_rst_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("held_rst_code", 32'(key_code), 32'(4'h0));
        checkOutput("held_rst_event", 32'(key_event), 32'(1'b0));
        applyStimulus(16'h0000);
        reset_dut();
        go_to(8);
        checkOutput("held_rst_no_spurious", 32'(event_count - base), 32'(1));

        // Randomized presses: random key, sometimes with a second key on the
        // same column. Each press must report the legend code of the lowest
        // pressed row, freeze on its column, and pulse exactly once.
        for (int it = 0; it < 16; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            keys = 16'(1) << (r * 4 + c);
            exp_row = r;
            if ($urandom_range(0, 1) == 1) begin
                r2 = $urandom_range(0, 3);
                keys = keys | (16'(1) << (r2 * 4 + c));
                if (r2 < exp_row) begin
                    exp_row = r2;
                end
            end
            exp_col = ~(4'b0001 << c);
            go_to(cyc + $urandom_range(0, 7));
            base = event_count;
            applyStimulus(keys);
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                go_to(cyc + 1);
                if (key_event === 1'b1) begin
                    got = 1'b1;
                end
            end
            checkOutput("rnd_event_seen", 32'(got), 32'(1'b1));
            if (got) begin
                checkOutput("rnd_code", 32'(key_code), 32'(KMAP[exp_row * 4 + c]));
                checkOutput("rnd_valid", 32'(key_valid), 32'(1'b1));
                checkOutput("rnd_col", 32'(col_out), 32'(exp_col));
            end
            go_to(cyc + $urandom_range(0, 20));
            applyStimulus(16'h0000);
            got = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                go_to(cyc + 1);
                if (key_valid === 1'b0) begin
                    got = 1'b1;
                end
            end
            checkOutput("rnd_release", 32'(got), 32'(1'b1));
            checkOutput("rnd_one_event", 32'(event_count - base), 32'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
